// File: rtl/pwm_rgb_driver.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_rgb_driver
//  Brief    : Three-channel PWM LED driver with period-aligned duty updates.
//  Revision : 1.0
// ============================================================================
module pwm_rgb_driver #(
    parameter int PWM_INTERVAL = 1200,
    parameter bit ACTIVE_LOW   = 1'b1,
    localparam int DW          = $clog2(PWM_INTERVAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_enable,
    input  logic          i_load,
    input  logic [DW-1:0] i_duty_r,
    input  logic [DW-1:0] i_duty_g,
    input  logic [DW-1:0] i_duty_b,
    output logic          o_led_r,
    output logic          o_led_g,
    output logic          o_led_b,
    output logic          o_period_start,
    output logic          o_update_ack,
    output logic          o_busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    // One extra bit so a clamped duty of PWM_INTERVAL fits even when it is a power of two.
    localparam int              c_AW   = DW + 1;
    localparam logic [DW-1:0]   c_LAST = DW'(PWM_INTERVAL - 1);
    localparam logic [c_AW-1:0] c_FULL = c_AW'(PWM_INTERVAL);
    localparam logic [2:0]      c_DARK = {3{ACTIVE_LOW}};

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [DW-1:0]         r_cnt;
    logic [DW-1:0]         w_next_cnt;
    logic [2:0][c_AW-1:0]  r_act;
    logic [2:0][c_AW-1:0]  r_pend;
    logic [2:0][c_AW-1:0]  w_duty_in;
    logic                  r_pend_valid;
    logic [2:0]            r_led;
    logic [2:0]            w_lit;
    logic                  r_period_start;
    logic                  r_update_ack;
    logic                  w_running;
    logic                  w_boundary;
    logic                  w_update;

    function automatic logic [c_AW-1:0] f_clamp(input logic [DW-1:0] d);
        return ({1'b0, d} >= c_FULL) ? c_FULL : {1'b0, d};
    endfunction

    assign w_duty_in[0] = f_clamp(i_duty_r);
    assign w_duty_in[1] = f_clamp(i_duty_g);
    assign w_duty_in[2] = f_clamp(i_duty_b);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    // Dropping enable on the last cycle of a period already completes that
    // period, so RUN goes straight to IDLE rather than draining a whole new one.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (i_enable) w_next_state = c_RUN;
            c_RUN:   if (!i_enable) w_next_state = w_boundary ? c_IDLE : c_DRAIN;
            c_DRAIN: begin
                if (i_enable) begin
                    w_next_state = c_RUN;
                end else if (w_boundary) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // ---------------- state decode ----------------
    always_comb begin
        w_running  = (r_state == c_RUN) || (r_state == c_DRAIN);
        w_boundary = w_running && (r_cnt == c_LAST);
        w_update   = ((r_state == c_IDLE) && i_enable) || w_boundary;
        o_busy     = w_running;
    end

    always_comb begin
        w_next_cnt = r_cnt + 1'b1;
        if ((r_state == c_IDLE) || w_boundary || (w_next_state == c_IDLE)) begin
            w_next_cnt = '0;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign w_lit[gi] = w_running && ({1'b0, r_cnt} < r_act[gi]);
        end
    endgenerate

    // ---------------- datapath ----------------
    // Active duties only change on an update event, so a period never sees a mid-way change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_act          <= '0;
            r_pend         <= '0;
            r_pend_valid   <= 1'b0;
            r_led          <= c_DARK;
            r_period_start <= 1'b0;
            r_update_ack   <= 1'b0;
        end else begin
            r_cnt          <= w_next_cnt;
            r_period_start <= (w_next_state == c_RUN) && (w_next_cnt == '0);
            r_update_ack   <= w_update && (i_load || r_pend_valid);
            r_led          <= w_lit ^ c_DARK;
            if (w_update) begin
                if (i_load) begin
                    r_act <= w_duty_in;
                end else if (r_pend_valid) begin
                    r_act <= r_pend;
                end
                r_pend_valid <= 1'b0;
            end else if (i_load) begin
                r_pend       <= w_duty_in;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign o_led_r        = r_led[0];
    assign o_led_g        = r_led[1];
    assign o_led_b        = r_led[2];
    assign o_period_start = r_period_start;
    assign o_update_ack   = r_update_ack;

endmodule
`default_nettype wire

// File: doc/pwm_rgb_driver.md
PWM_RGB_DRIVER -- requirements
Module: pwm_rgb_driver

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200, giving the PWM period in clk cycles (100 us at 12 MHz).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1; 1 means LED outputs drive 0 when lit.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL define DW = $clog2(PWM_INTERVAL) as the duty width (11 at default).
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; asynchronous assert, active-high.
REQ-007 enable  input  1  run request; level-sensitive.
REQ-008 load  input  1  single-cycle strobe that captures the three duty inputs.
REQ-009 duty_r, duty_g, duty_b  input  DW each  requested on-time in clk cycles per period; driven by the upstream fade stage.
REQ-010 led_r, led_g, led_b  output  1 each  registered PWM outputs; polarity set by ACTIVE_LOW.
REQ-011 period_start  output  1  one-cycle pulse on the first cycle of each running period.
REQ-012 update_ack  output  1  one-cycle pulse when pending duties become active.
REQ-013 busy  output  1  high when state is RUN or DRAIN.

Function
REQ-014 SHALL implement states IDLE, RUN and DRAIN.
REQ-015 Counter cnt SHALL count 0..PWM_INTERVAL-1 and wrap to 0 in RUN/DRAIN; held at 0 in IDLE.
REQ-016 Boundary SHALL be defined as a cycle in RUN/DRAIN with cnt == PWM_INTERVAL-1.
REQ-017 load=1 SHALL capture duty_r/g/b into pending registers next edge and set pend_valid; a later load overwrites (last wins).
REQ-018 At a boundary with pend_valid=1, active duties SHALL take the pending values, pend_valid SHALL clear, and update_ack SHALL pulse in the following cycle (cnt==0).
REQ-019 load on a boundary cycle SHALL take effect at that same boundary (bypass of the pending registers).
REQ-020 Active duties SHALL never change mid-period (glitch-free update).
REQ-021 Duty values >= PWM_INTERVAL SHALL be clamped to PWM_INTERVAL (channel always lit); duty 0 SHALL mean always dark.
REQ-022 Channel lit value SHALL be (cnt < active_duty), registered: LED in cycle t+1 reflects cnt and active duty at cycle t (one-cycle latency).
REQ-023 IDLE->RUN SHALL occur on enable=1; on entry cnt=0, and pending duties (if pend_valid) load into active with an update_ack pulse.
REQ-024 RUN->DRAIN SHALL occur on enable=0; DRAIN SHALL finish the current period, then go to IDLE at the boundary.
REQ-025 enable=1 in DRAIN SHALL return to RUN with no counter disturbance.
REQ-026 period_start SHALL pulse when cnt==0 in RUN, including on IDLE->RUN entry; it SHALL NOT pulse in DRAIN.
REQ-027 In IDLE all LEDs SHALL be dark (1 if ACTIVE_LOW else 0); load still captures into pending.

Reset
REQ-028 rst SHALL asynchronously force state=IDLE, cnt=0, active and pending duties=0, pend_valid=0, LEDs dark, period_start=0, update_ack=0, busy=0.
REQ-029 rst mid-period SHALL discard pending updates; after release, the block SHALL wait in IDLE for enable.

Verification
REQ-030 Reset, then enable=1 with load duty_r=600, duty_g=0, duty_b=1200 before enable -> led_r lit 600 cycles/dark 600 cycles; led_g always dark; led_b always lit; period_start every 1200 cycles.
REQ-031 Load duty_r=300 at cnt=500 while running 600 -> current period stays 600; next period 300; update_ack one pulse coinciding with cnt==0.
REQ-032 Load on the boundary cycle (cnt=1199) with duty_r=900 -> the very next period uses 900.
REQ-033 duty_g=2047 -> clamped; led_g lit for all 1200 cycles.
REQ-034 Drop enable at cnt=100 -> PWM continues to cnt=1199, then IDLE with LEDs dark and busy=0; no period_start in DRAIN; re-raise enable during DRAIN -> RUN resumes with the count continuous.
REQ-035 Assert rst at cnt=700 with pend_valid=1 -> LEDs dark immediately; after release and enable, duties are 0 (all dark) until a new load.
